// File: rtl/fact_bus_top.sv
// Single-master bus subsystem: grant register, address decode, 256x64 word memory
// and a memory-mapped iterative factorial core with a level done-interrupt.
module fact_bus_top #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_req,
  input  logic        m_wr,
  input  logic [15:0] m_addr,
  input  logic [63:0] m_dout,
  output logic        m_grant,
  output logic [63:0] m_din,
  output logic        interrupt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [63:0]  r_mem [0:MEM_DEPTH-1];
  logic         r_grant;
  state_t       r_state;
  logic         r_opstart;
  logic         r_opclear;
  logic         r_opdone;
  logic         r_intr_en;
  logic [63:0]  r_operand;
  logic [63:0]  r_mult;
  logic [127:0] r_result;

  logic         w_valid;
  logic         w_mem_sel;
  logic         w_core_sel;
  logic         w_mem_wr;
  logic         w_core_wr;
  logic [2:0]   w_reg_idx;
  logic [127:0] w_product;
  logic [63:0]  w_din;

  assign w_valid    = m_req & r_grant;
  assign w_mem_sel  = (m_addr[15:8] == 8'h00);
  assign w_core_sel = (m_addr[15:6] == 10'h1C0);
  assign w_mem_wr   = w_valid & m_wr & w_mem_sel;
  assign w_core_wr  = w_valid & m_wr & w_core_sel;
  assign w_reg_idx  = m_addr[5:3];
  assign w_product  = r_result * {64'd0, r_mult};

  // Bus grant simply follows the request one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant <= 1'b0;
    end else begin
      r_grant <= m_req;
    end
  end

  // Word memory write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[m_addr[7:0]] <= m_dout;
    end
  end

  // Core register writes and the factorial FSM; a set opclear overrides everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_opstart <= 1'b0;
      r_opclear <= 1'b0;
      r_opdone  <= 1'b0;
      r_intr_en <= 1'b0;
      r_operand <= 64'd0;
      r_mult    <= 64'd0;
      r_result  <= 128'd0;
    end else begin
      if (w_core_wr) begin
        case (w_reg_idx)
          3'd0:    r_opstart <= m_dout[0];
          3'd1:    r_opclear <= m_dout[0];
          3'd3:    r_intr_en <= m_dout[0];
          3'd4:    r_operand <= m_dout;
          default: ;
        endcase
      end
      if (r_opclear) begin
        r_state   <= ST_IDLE;
        r_opstart <= 1'b0;
        r_opdone  <= 1'b0;
        r_mult    <= 64'd0;
        r_result  <= 128'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_opstart) begin
              r_mult   <= r_operand;
              r_result <= 128'd1;
              r_state  <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (r_mult <= 64'd1) begin
              r_opdone <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_result <= w_product;
              r_mult   <= r_mult - 64'd1;
            end
          end
          ST_DONE: r_opdone <= 1'b1;
          default: r_state  <= ST_IDLE;
        endcase
      end
    end
  end

  // Read data path: selected slave when a granted read is in progress, else zero
  always_comb begin
    w_din = 64'd0;
    if (w_valid && !m_wr) begin
      if (w_mem_sel) begin
        w_din = r_mem[m_addr[7:0]];
      end else if (w_core_sel) begin
        case (w_reg_idx)
          3'd0:    w_din = {63'd0, r_opstart};
          3'd1:    w_din = {63'd0, r_opclear};
          3'd2:    w_din = {63'd0, r_opdone};
          3'd3:    w_din = {63'd0, r_intr_en};
          3'd4:    w_din = r_operand;
          3'd5:    w_din = r_result[127:64];
          3'd6:    w_din = r_result[63:0];
          default: w_din = 64'd0;
        endcase
      end else begin
        w_din = 64'd0;
      end
    end else begin
      w_din = 64'd0;
    end
  end

  assign m_grant   = r_grant;
  assign m_din     = w_din;
  assign interrupt = r_opdone & r_intr_en;

endmodule

// File: tb/tb_fact_bus_top.sv
// Randomized self-checking bench for fact_bus_top against a behavioural model.
module tb_fact_bus_top;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;
  logic        interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem_model [256];
  logic        mem_known [256];

  localparam logic [15:0] A_START = 16'h7000, A_CLEAR = 16'h7008, A_DONE = 16'h7010,
                          A_IEN = 16'h7018, A_OPND = 16'h7020, A_RH = 16'h7028,
                          A_RL = 16'h7030, A_R7 = 16'h7038;

  fact_bus_top dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_dout(m_dout), .m_grant(m_grant), .m_din(m_din), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] fact(input int n);
    logic [127:0] r = 128'd1;
    for (int k = 2; k <= n; k++) r = r * 128'(k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [63:0] d);
    m_wr = 1'b1; m_addr = a; m_dout = d;
    tick();
    m_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [63:0] d);
    m_wr = 1'b0; m_addr = a;
    #1;
    d = m_din;
  endtask

  task automatic start_run(input int n);
    bus_write(A_CLEAR, 64'd1);
    bus_write(A_CLEAR, 64'd0);
    bus_write(A_OPND, 64'(n));
    bus_write(A_START, 64'd1);
  endtask

  // Polls opdone under a cycle budget; an expired budget is reported as a failure
  task automatic wait_done(input string tag, input int n, output int cyc);
    logic [63:0] d;
    int lim;
    lim = ((n < 1) ? 1 : n) + 3;
    cyc = 0;
    bus_read(A_DONE, d);
    while (d[0] !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      bus_read(A_DONE, d);
    end
    check_eq({tag, "_latency"}, 128'(cyc <= lim), 128'd1);
  endtask

  task automatic check_result(input string tag, input int n, input logic ie);
    logic [63:0] d;
    logic [127:0] exp;
    exp = fact(n);
    bus_read(A_DONE, d); check_eq({tag, "_opdone"}, d, 128'd1);
    check_eq({tag, "_irq"}, interrupt, 128'(ie));
    bus_read(A_RH, d); check_eq({tag, "_res_h"}, d, exp[127:64]);
    bus_read(A_RL, d); check_eq({tag, "_res_l"}, d, exp[63:0]);
  endtask

  initial begin
    logic [63:0] d, d2;
    logic [15:0] a;
    logic [63:0] v;
    logic ie;
    int cyc, n;

    for (int i = 0; i < 256; i++) mem_known[i] = 1'b0;
    reset_n = 1'b0; m_req = 1'b0; m_wr = 1'b0; m_addr = 16'd0; m_dout = 64'd0;
    #12;
    check_eq("rst_grant", m_grant, 128'd0);
    check_eq("rst_din", m_din, 128'd0);
    check_eq("rst_irq", interrupt, 128'd0);
    reset_n = 1'b1;
    tick();

    m_req = 1'b1;
    #1 check_eq("grant_delay", m_grant, 128'd0);
    tick();
    check_eq("grant_on", m_grant, 128'd1);

    bus_write(A_IEN, 64'd1);
    start_run(12);
    wait_done("f12", 12, cyc);
    check_result("f12", 12, 1'b1);
    check_eq("f12_lit", fact(12), 128'h1C8CFC00);

    bus_read(A_RH, d); bus_write(16'h000a, d); mem_model[8'h0a] = d; mem_known[8'h0a] = 1'b1;
    bus_read(A_RL, d); bus_write(16'h000b, d); mem_model[8'h0b] = d; mem_known[8'h0b] = 1'b1;
    bus_read(16'h000a, d); check_eq("copy_h", d, 128'h0);
    bus_read(16'h000b, d); check_eq("copy_l", d, 128'h1C8CFC00);

    bus_write(A_CLEAR, 64'd1);
    tick();
    bus_read(A_DONE, d); check_eq("clr_opdone", d, 128'd0);
    check_eq("clr_irq", interrupt, 128'd0);
    bus_read(A_RL, d); check_eq("clr_res_l", d, 128'd0);
    bus_read(A_START, d); check_eq("clr_opstart", d, 128'd0);
    bus_read(A_OPND, d); check_eq("clr_operand_kept", d, 128'd12);
    bus_read(A_IEN, d); check_eq("clr_ien_kept", d, 128'd1);
    bus_write(A_CLEAR, 64'd0);

    start_run(0); wait_done("f0", 0, cyc); check_result("f0", 0, 1'b1);
    start_run(1); wait_done("f1", 1, cyc); check_result("f1", 1, 1'b1);
    start_run(21); wait_done("f21", 21, cyc); check_result("f21", 21, 1'b1);
    check_eq("f21_lit", fact(21), 128'h2_C5077D36B8C40000);

    bus_write(A_IEN, 64'd0);
    #1 check_eq("ien0_irq", interrupt, 128'd0);

    // A second start while done must not restart the computation
    bus_write(A_OPND, 64'd5);
    bus_write(A_START, 64'd1);
    repeat (10) tick();
    check_result("norestart", 21, 1'b0);

    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(0, 40));
      ie = 1'($urandom_range(0, 1));
      bus_write(A_IEN, 64'(ie));
      start_run(n);
      bus_write(A_OPND, {$urandom(), $urandom()});
      wait_done($sformatf("rnd%0d_n%0d", it, n), n, cyc);
      check_result($sformatf("rnd%0d_n%0d", it, n), n, ie);
    end

    for (int it = 0; it < 24; it++) begin
      a = 16'($urandom_range(0, 255));
      v = {$urandom(), $urandom()};
      bus_write(a, v);
      mem_model[a[7:0]] = v; mem_known[a[7:0]] = 1'b1;
      a = 16'($urandom_range(16'h0100, 16'h6FFF));
      bus_write(a, {$urandom(), $urandom()});
      bus_read(a, d); check_eq($sformatf("unmapped_%0h", a), d, 128'd0);
    end
    for (int i = 0; i < 256; i++) begin
      if (mem_known[i]) begin
        bus_read(16'(i), d);
        check_eq($sformatf("mem_%0d", i), d, mem_model[i]);
      end
    end
    bus_read(16'h5000, d); check_eq("read_5000", d, 128'd0);
    bus_read(A_R7, d); check_eq("read_7038", d, 128'd0);

    m_req = 1'b0;
    bus_write(16'h000a, 64'hDEAD_BEEF_0000_0001);
    check_eq("grant_off", m_grant, 128'd0);
    bus_read(16'h000a, d); check_eq("noreq_din", d, 128'd0);
    m_req = 1'b1;
    tick();
    bus_read(16'h000a, d); check_eq("noreq_write_ignored", d, mem_model[8'h0a]);

    bus_write(A_IEN, 64'd1);
    start_run(30);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check_eq("midrst_grant", m_grant, 128'd0);
    check_eq("midrst_irq", interrupt, 128'd0);
    reset_n = 1'b1;
    tick();
    tick();
    bus_read(A_RL, d); check_eq("midrst_res_l", d, 128'd0);
    bus_read(A_OPND, d2); check_eq("midrst_operand", d2, 128'd0);
    bus_read(A_IEN, d); check_eq("midrst_ien", d, 128'd0);
    repeat (40) tick();
    bus_read(A_DONE, d); check_eq("midrst_idle", d, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
